// File: rtl/tt_cm_tile_palette_engine_if.sv
// Avalon-MM slave bundle for the tile/palette engine.
// Ports: address/write/writedata/read in, readdata/readdatavalid out.
interface tt_cm_tile_palette_engine_if;
    logic [11:0] avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;

    modport master (
        output avs_address,
        output avs_write,
        output avs_writedata,
        output avs_read,
        input  avs_readdata,
        input  avs_readdatavalid
    );

    modport slave (
        input  avs_address,
        input  avs_write,
        input  avs_writedata,
        input  avs_read,
        output avs_readdata,
        output avs_readdatavalid
    );
endinterface

// File: rtl/tt_cm_tile_palette_engine.sv
// Tile-map + double-buffered palette pixel engine, 3-cycle latency.
// Ports: clk_clk, reset_reset_n, avs (Avalon slave), tt_cm_x/y in,
// tt_cm_r/g/b out, vga_vs in, irq out.
// Macro TT_CM_SWAP_IRQ_EN enables the swap-done interrupt flop.
module tt_cm_tile_palette_engine #(
    parameter int X_W        = 10,
    parameter int Y_W        = 10,
    parameter int TILE_SHIFT = 4,
    parameter int MAP_COLS   = 40,
    parameter int MAP_ROWS   = 30,
    parameter int IDX_W      = 4,
    parameter int COLOR_W    = 8
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    tt_cm_tile_palette_engine_if.slave avs,
    input  logic [X_W-1:0]     tt_cm_x,
    input  logic [Y_W-1:0]     tt_cm_y,
    output logic [COLOR_W-1:0] tt_cm_r,
    output logic [COLOR_W-1:0] tt_cm_g,
    output logic [COLOR_W-1:0] tt_cm_b,
    input  logic               vga_vs,
    output logic               irq
);

    localparam int RGB_W  = 3 * COLOR_W;
    localparam int PAL_N  = 1 << IDX_W;
    localparam int MAP_N  = MAP_COLS * MAP_ROWS;
    localparam int MAP_AW = $clog2(MAP_N);
    localparam int CW     = X_W - TILE_SHIFT;
    localparam int RW     = Y_W - TILE_SHIFT;

    localparam logic [12:0] PAL_LIM = 13'(256 + PAL_N);
    localparam logic [12:0] MAP_LIM = 13'(2048 + MAP_N);

    // Storage (contents intentionally not reset)
    logic [IDX_W-1:0] map_mem [MAP_N];
    logic [RGB_W-1:0] pal_mem [2][PAL_N];

    // Pipeline state
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic             oob1_q, oob1_d;
    logic             v1_q;
    logic [IDX_W-1:0] map_rd_q;
    logic             oob2_q;
    logic             v2_q;
    logic [RGB_W-1:0] rgb_q, rgb_d;

    // Control state
    logic [RGB_W-1:0] border_q, border_d;
    logic             active_bank_q, active_bank_d;
    logic             swap_pending_q, swap_pending_d;
    logic             vs_meta_q, vs_sync_q, vs_prev_q;
    logic [31:0]      rdata_q, rdata_d;
    logic             rvalid_q;

    // Decode
    logic              ctrl_hit, border_hit, pal_hit, map_hit;
    logic              ctrl_we, border_we, pal_we, map_we;
    logic [IDX_W-1:0]  pal_widx;
    logic [MAP_AW-1:0] map_widx;
    logic [MAP_AW-1:0] map_raddr;
    logic              shadow_bank;
    logic              vs_fall, swap;

    logic unused_bits;
    assign unused_bits = ^{avs.avs_writedata[31:RGB_W],
                           tt_cm_x[TILE_SHIFT-1:0],
                           tt_cm_y[TILE_SHIFT-1:0]};

    assign shadow_bank = ~active_bank_q;

    always_comb begin
        ctrl_hit   = (avs.avs_address == 12'h000);
        border_hit = (avs.avs_address == 12'h001);
        pal_hit    = (avs.avs_address >= 12'h100) &&
                     ({1'b0, avs.avs_address} < PAL_LIM);
        map_hit    = (avs.avs_address >= 12'h800) &&
                     ({1'b0, avs.avs_address} < MAP_LIM);
        pal_widx   = IDX_W'(avs.avs_address - 12'h100);
        map_widx   = MAP_AW'(avs.avs_address - 12'h800);
        ctrl_we    = avs.avs_write && ctrl_hit;
        border_we  = avs.avs_write && border_hit;
        pal_we     = avs.avs_write && pal_hit;
        map_we     = avs.avs_write && map_hit;
    end

    // S1: tile coordinates and out-of-map flag
    always_comb begin
        col_d  = tt_cm_x[X_W-1:TILE_SHIFT];
        row_d  = tt_cm_y[Y_W-1:TILE_SHIFT];
        oob1_d = (32'(col_d) >= 32'(MAP_COLS)) ||
                 (32'(row_d) >= 32'(MAP_ROWS));
    end

    // S2 address; oob pixels read entry 0 and are overridden later
    always_comb begin
        map_raddr = '0;
        if (!oob1_q) begin
            map_raddr = MAP_AW'(32'(row_q) * 32'(MAP_COLS)
                                + 32'(col_q));
        end
    end

    // Synchronous RAMs: the same-edge read returns the old word
    always_ff @(posedge clk_clk) begin
        if (map_we) begin
            map_mem[map_widx] <= avs.avs_writedata[IDX_W-1:0];
        end
        map_rd_q <= map_mem[map_raddr];
    end

    always_ff @(posedge clk_clk) begin
        if (pal_we) begin
            pal_mem[shadow_bank][pal_widx] <=
                avs.avs_writedata[RGB_W-1:0];
        end
    end

    // S3: colour lookup; invalid slots after reset output black
    always_comb begin
        rgb_d = '0;
        if (v2_q) begin
            if (oob2_q) begin
                rgb_d = border_q;
            end else begin
                rgb_d = pal_mem[active_bank_q][map_rd_q];
            end
        end
    end

    // Bank swap on synchronised vsync falling edge
    always_comb begin
        vs_fall        = vs_prev_q & ~vs_sync_q;
        swap           = vs_fall & swap_pending_q;
        active_bank_d  = active_bank_q ^ swap;
        swap_pending_d = swap ? 1'b0 : swap_pending_q;
        if (ctrl_we && avs.avs_writedata[0]) begin
            swap_pending_d = 1'b1;
        end
        border_d = border_q;
        if (border_we) begin
            border_d = avs.avs_writedata[RGB_W-1:0];
        end
    end

    // Register read mux
    always_comb begin
        rdata_d = '0;
        if (avs.avs_read) begin
            if (ctrl_hit) begin
                rdata_d = {30'b0, active_bank_q, swap_pending_q};
            end else if (border_hit) begin
                rdata_d = 32'(border_q);
            end else if (pal_hit) begin
                rdata_d = 32'(pal_mem[shadow_bank][pal_widx]);
            end else if (map_hit) begin
                rdata_d = 32'(map_mem[map_widx]);
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            col_q          <= '0;
            row_q          <= '0;
            oob1_q         <= 1'b0;
            v1_q           <= 1'b0;
            oob2_q         <= 1'b0;
            v2_q           <= 1'b0;
            rgb_q          <= '0;
            border_q       <= '0;
            active_bank_q  <= 1'b0;
            swap_pending_q <= 1'b0;
            vs_meta_q      <= 1'b1;
            vs_sync_q      <= 1'b1;
            vs_prev_q      <= 1'b1;
            rdata_q        <= '0;
            rvalid_q       <= 1'b0;
        end else begin
            col_q          <= col_d;
            row_q          <= row_d;
            oob1_q         <= oob1_d;
            v1_q           <= 1'b1;
            oob2_q         <= oob1_q;
            v2_q           <= v1_q;
            rgb_q          <= rgb_d;
            border_q       <= border_d;
            active_bank_q  <= active_bank_d;
            swap_pending_q <= swap_pending_d;
            vs_meta_q      <= vga_vs;
            vs_sync_q      <= vs_meta_q;
            vs_prev_q      <= vs_sync_q;
            rdata_q        <= rdata_d;
            rvalid_q       <= avs.avs_read;
        end
    end

`ifdef TT_CM_SWAP_IRQ_EN
    logic swap_q;
    logic irq_q, irq_d;

    // Set (one cycle after the swap) wins over a same-cycle clear
    always_comb begin
        irq_d = irq_q;
        if (ctrl_we && avs.avs_writedata[1]) begin
            irq_d = 1'b0;
        end
        if (swap_q) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            swap_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            swap_q <= swap;
            irq_q  <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign avs.avs_readdata      = rdata_q;
    assign avs.avs_readdatavalid = rvalid_q;

    assign tt_cm_r = rgb_q[3*COLOR_W-1:2*COLOR_W];
    assign tt_cm_g = rgb_q[2*COLOR_W-1:COLOR_W];
    assign tt_cm_b = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_tt_cm_tile_palette_engine.sv
// Directed bench for tt_cm_tile_palette_engine.
// Table-driven pixel vectors plus hand-written swap/collision/reset cases.
module tb_tt_cm_tile_palette_engine;

`ifdef TT_CM_SWAP_IRQ_EN
    localparam logic IRQ_EN = 1'b1;
`else
    localparam logic IRQ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] px = '0;
    logic [9:0] py = '0;
    logic [7:0] r, g, b;
    logic       vs = 1'b1;
    logic       irq;

    int checks = 0;
    int errors = 0;

    tt_cm_tile_palette_engine_if bus ();

    tt_cm_tile_palette_engine dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .avs           (bus),
        .tt_cm_x       (px),
        .tt_cm_y       (py),
        .tt_cm_r       (r),
        .tt_cm_g       (g),
        .tt_cm_b       (b),
        .vga_vs        (vs),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [23:0] rgb;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        bus.avs_address   = a;
        bus.avs_writedata = d;
        bus.avs_write     = 1'b1;
        @(posedge clk);
        #1;
        bus.avs_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [11:0] a, input logic [31:0] exp,
                            input string name);
        @(posedge clk);
        #1;
        bus.avs_address = a;
        bus.avs_read    = 1'b1;
        @(posedge clk);
        #1;
        bus.avs_read    = 1'b0;
        check({name, "_valid"}, 32'(bus.avs_readdatavalid), 32'd1);
        check(name, bus.avs_readdata, exp);
        @(posedge clk);
        #1;
        check({name, "_idle"},
              {bus.avs_readdata[30:0], bus.avs_readdatavalid}, 32'd0);
    endtask

    task automatic pix(input logic [9:0] x, input logic [9:0] y,
                       input logic [23:0] exp, input string name);
        @(posedge clk);
        #1;
        px = x;
        py = y;
        repeat (3) @(posedge clk);
        #1;
        check(name, 32'({r, g, b}), 32'(exp));
    endtask

    task automatic vsync_pulse();
        @(posedge clk);
        #1;
        vs = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        vs = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        vecs[0] = '{10'd5,    10'd7,    24'h112233};
        vecs[1] = '{10'd16,   10'd0,    24'h445566};
        vecs[2] = '{10'd20,   10'd20,   24'h778899};
        vecs[3] = '{10'd640,  10'd0,    24'hFF00FF};
        vecs[4] = '{10'd639,  10'd480,  24'hFF00FF};
        vecs[5] = '{10'd639,  10'd479,  24'hABCDEF};
        vecs[6] = '{10'd1023, 10'd1023, 24'hFF00FF};
        vecs[7] = '{10'd15,   10'd15,   24'h112233};

        bus.avs_address   = '0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = '0;
        bus.avs_read      = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rgb", 32'({r, g, b}), 32'd0);
        check("rst_rdv", 32'(bus.avs_readdatavalid), 32'd0);
        check("rst_rdata", bus.avs_readdata, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        rst_n = 1'b1;
        bus_read(12'h000, 32'h0, "ctrl_rst");

        // Setup: border, map, shadow bank 1
        bus_write(12'h001, 32'h00FF00FF);
        bus_write(12'h800, 32'd3);
        bus_write(12'h801, 32'd1);
        bus_write(12'h829, 32'd2);
        bus_write(12'hCAF, 32'd5);
        bus_write(12'h103, 32'h00112233);
        bus_write(12'h101, 32'h00445566);
        bus_write(12'h102, 32'h00778899);
        bus_write(12'h105, 32'h00ABCDEF);
        bus_read(12'h103, 32'h00112233, "pal_shadow_rd");
        bus_read(12'h001, 32'h00FF00FF, "border_rd");

        // First swap
        bus_write(12'h000, 32'h1);
        bus_read(12'h000, 32'h1, "ctrl_pending");
        vsync_pulse();
        bus_read(12'h000, 32'h2, "ctrl_swapped");
        check("irq_swap1", 32'(irq), 32'(IRQ_EN));
        bus_write(12'h000, 32'h2);
        #1;
        check("irq_clear1", 32'(irq), 32'd0);

        // Streaming vectors, one pixel per cycle
        for (int c = 0; c < 11; c++) begin
            @(posedge clk);
            #1;
            if (c < 8) begin
                px = vecs[c].x;
                py = vecs[c].y;
            end
            if (c >= 3) begin
                check($sformatf("vec%0d", c - 3), 32'({r, g, b}),
                      32'(vecs[c - 3].rgb));
            end
        end

        // Map write colliding with S2 read of tile 0
        @(posedge clk);
        #1;
        px = 10'd0;
        py = 10'd0;
        @(posedge clk);
        #1;
        px = 10'd1;
        bus.avs_address   = 12'h800;
        bus.avs_writedata = 32'd5;
        bus.avs_write     = 1'b1;
        @(posedge clk);
        #1;
        bus.avs_write = 1'b0;
        px = 10'd2;
        @(posedge clk);
        #1;
        check("coll_old", 32'({r, g, b}), 32'h112233);
        @(posedge clk);
        #1;
        check("coll_new", 32'({r, g, b}), 32'hABCDEF);
        bus_write(12'h800, 32'd3);

        // Shadow write does not affect the visible frame
        bus_write(12'h103, 32'h000000FF);
        pix(10'd5, 10'd7, 24'h112233, "shadow_hidden");
        bus_read(12'h103, 32'h000000FF, "pal_shadow_rd2");
        bus_read(12'h800, 32'd3, "map_rd");
        bus_read(12'h002, 32'd0, "unmapped_rd");
        bus_read(12'h7FF, 32'd0, "unmapped_rd2");
        bus_write(12'h000, 32'h1);
        bus_read(12'h000, 32'h3, "ctrl_pending2");
        pix(10'd5, 10'd7, 24'h112233, "pending_hidden");
        vsync_pulse();
        bus_read(12'h000, 32'h0, "ctrl_swapped2");
        pix(10'd5, 10'd7, 24'h0000FF, "swap_visible");
        check("irq_swap2", 32'(irq), 32'(IRQ_EN));
        bus_write(12'h000, 32'h2);

        // Request in the same cycle as the synchronised edge
        @(posedge clk);
        #1;
        vs = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.avs_address   = 12'h000;
        bus.avs_writedata = 32'h1;
        bus.avs_write     = 1'b1;
        @(posedge clk);
        #1;
        bus.avs_write = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        vs = 1'b1;
        repeat (4) @(posedge clk);
        bus_read(12'h000, 32'h1, "edge_req_pending");
        bus_write(12'h000, 32'h1);
        bus_read(12'h000, 32'h1, "double_req");
        check("irq_no_swap", 32'(irq), 32'd0);
        vsync_pulse();
        bus_read(12'h000, 32'h2, "edge_req_swapped");
        pix(10'd5, 10'd7, 24'h112233, "bank1_again");

        // Reset mid-pipeline
        @(posedge clk);
        #1;
        px = 10'd5;
        py = 10'd7;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_rgb0", 32'({r, g, b}), 32'd0);
        @(posedge clk);
        #1;
        check("midrst_rgb1", 32'({r, g, b}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_c1", 32'({r, g, b}), 32'd0);
        @(posedge clk);
        #1;
        check("post_rst_c2", 32'({r, g, b}), 32'd0);
        @(posedge clk);
        #1;
        check("post_rst_c3", 32'({r, g, b}), 32'h0000FF);
        check("post_rst_irq", 32'(irq), 32'd0);
        bus_read(12'h000, 32'h0, "ctrl_post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
